// File: rtl/bytestream_rx_fifo_pkg.sv
// Shared constants and helpers for the receive-side byte FIFO.
// Drop accounting saturates rather than wrapping.
package bytestream_rx_fifo_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam logic [7:0]  DROP_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bytestream_rx_fifo.sv
// Elastic buffer behind the UART bytestream: FWFT output, drop-on-full
// input with sticky overflow and a saturating drop counter.
module bytestream_rx_fifo
    import bytestream_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_produce,
    output logic [BYTE_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_consume,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  flush,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic [7:0]            drop_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic [BYTE_W-1:0] mem [DEPTH];

    logic [PW-1:0] level_w;
    logic          empty, full;
    logic          rd, wr, drop, mem_we;

    assign level_w = wr_ptr_q - rd_ptr_q;
    assign empty   = (level_w == '0);
    assign full    = (level_w == PW'(DEPTH));

    always_comb begin
        rd           = out_consume && !empty;
        wr           = in_produce && (!full || rd);
        drop         = in_produce && full && !rd;
        mem_we       = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        // Flush discards everything, including a byte arriving this cycle.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (rd) rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                mem_we   = 1'b1;
            end
        end

        if (drop && !flush) begin
            overflow_d   = 1'b1;
            drop_count_d = overflow_clear ? 8'd1 : sat_inc(drop_count_q);
        end else if (overflow_clear) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is deliberately not reset so it maps to distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
    end

    assign out_valid  = !empty;
    assign out_data   = out_valid ? mem[rd_ptr_q[DEPTH_LOG2-1:0]] : '0;
    assign level      = level_w;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_bytestream_rx_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against
// a queue-based reference model of the FIFO.
module tb_bytestream_rx_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_produce = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_consume = 1'b0;
    logic [4:0] level;
    logic       flush = 1'b0;
    logic       overflow;
    logic       overflow_clear = 1'b0;
    logic [7:0] drop_count;

    int errors = 0;
    int checks = 0;

    byte unsigned m_q[$];
    bit           m_ov = 0;
    int           m_dc = 0;

    bytestream_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_produce(in_produce),
        .out_data(out_data), .out_valid(out_valid),
        .out_consume(out_consume), .level(level),
        .flush(flush), .overflow(overflow),
        .overflow_clear(overflow_clear), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] exp_d;
        exp_d = (m_q.size() != 0) ? m_q[0] : 8'h00;
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m_q.size() != 0});
        chk({tag, ".data"}, {24'b0, out_data}, {24'b0, exp_d});
        chk({tag, ".level"}, {27'b0, level}, m_q.size());
        chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, m_ov});
        chk({tag, ".drops"}, {24'b0, drop_count}, m_dc);
    endtask

    // Called #1 after a clock edge; applies inputs for the next edge.
    task automatic step(input string tag, input bit prod, input byte unsigned d,
                        input bit cons, input bit fl, input bit clr);
        bit full, rd, drp;
        in_produce = prod; in_data = d; out_consume = cons;
        flush = fl; overflow_clear = clr;
        full = (m_q.size() == 16);
        rd   = cons && (m_q.size() != 0);
        if (fl) begin
            m_q.delete();
            if (clr) begin m_ov = 0; m_dc = 0; end
        end else begin
            drp = prod && full && !rd;
            if (rd) void'(m_q.pop_front());
            if (prod && !drp) m_q.push_back(d);
            if (drp) begin
                m_ov = 1;
                m_dc = clr ? 1 : ((m_dc == 255) ? 255 : m_dc + 1);
            end else if (clr) begin
                m_ov = 0; m_dc = 0;
            end
        end
        @(posedge clk); #1;
        in_produce = 0; out_consume = 0; flush = 0; overflow_clear = 0;
        check_model(tag);
    endtask

    task automatic model_reset();
        m_q.delete(); m_ov = 0; m_dc = 0;
    endtask

    initial begin
        int maxl;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_model("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        step("ord_w0", 1, 8'h41, 0, 0, 0);
        step("ord_w1", 1, 8'h42, 0, 0, 0);
        step("ord_w2", 1, 8'h43, 0, 0, 0);
        chk("ord_level3", {27'b0, level}, 3);
        chk("ord_head", {24'b0, out_data}, 8'h41);
        for (int i = 0; i < 3; i++) step("ord_rd", 0, 0, 1, 0, 0);
        chk("ord_empty_valid", {31'b0, out_valid}, 0);
        chk("ord_empty_data", {24'b0, out_data}, 0);

        for (int i = 0; i < 18; i++) step("full_w", 1, byte'(i), 0, 0, 0);
        chk("full_level", {27'b0, level}, 16);
        chk("full_ovf", {31'b0, overflow}, 1);
        chk("full_drops", {24'b0, drop_count}, 2);

        step("full_rw", 1, 8'hAA, 1, 0, 0);
        chk("full_rw_level", {27'b0, level}, 16);
        chk("full_rw_drops", {24'b0, drop_count}, 2);
        for (int i = 0; i < 16; i++) step("full_drain", 0, 0, 1, 0, 0);
        step("clr", 0, 0, 0, 0, 1);

        maxl = 0;
        for (int i = 0; i < 41; i++) begin
            step("wrap", i < 40, byte'(i), i > 0, 0, 0);
            if (int'(level) > maxl) maxl = int'(level);
        end
        chk("wrap_maxlvl", {31'b0, maxl <= 2}, 1);
        chk("wrap_ovf", {31'b0, overflow}, 0);

        for (int i = 0; i < 5; i++) step("fl_w", 1, byte'(8'h60 + i), 0, 0, 0);
        step("flush", 1, 8'h55, 0, 1, 0);
        chk("flush_level", {27'b0, level}, 0);
        chk("flush_drops", {24'b0, drop_count}, 0);

        for (int i = 0; i < 16; i++) step("cd_w", 1, byte'($urandom), 0, 0, 0);
        step("cd_drop", 1, 8'h77, 0, 0, 1);
        chk("cd_ovf", {31'b0, overflow}, 1);
        chk("cd_drops", {24'b0, drop_count}, 1);

        for (int i = 0; i < 260; i++) step("sat", 1, byte'($urandom), 0, 0, 0);
        chk("sat_drops", {24'b0, drop_count}, 255);

        for (int i = 0; i < 9; i++) step("ar_rd", 0, 0, 1, 0, 0);
        chk("ar_pre_level", {27'b0, level}, 7);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
        check_model("post_rst");

        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 3) != 0, byte'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 30) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
